// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index of the set bit in a one-hot vector; 0 when no bit is set.
    function automatic int unsigned onehot_to_idx(input logic [31:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rtl/fifo_write_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    logic [IW-1:0]    start;
    logic [N_REQ-1:0] rot;
    logic [IW-1:0]    off;

    // Modulo-N_REQ add by compare, so non-power-of-two N_REQ wraps correctly.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > (IW+1)'(N_REQ - 1)) sum = sum - (IW+1)'(N_REQ);
        return sum[IW-1:0];
    endfunction

    assign start = (rr_ptr == IW'(N_REQ - 1)) ? '0 : rr_ptr + 1'b1;

    always_comb begin
        rot = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rot[k] = req[wrap_add(start, IW'(k))];
        end
    end

    always_comb begin
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
    end

    assign found = |rot;
    assign idx   = wrap_add(start, off);

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter for an async FIFO write port
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         last,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         accept,
    input  logic                     fifo_wenable,
    output logic                     fifo_winc,
    output logic [DW-1:0]            fifo_wdata,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] owner
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t       state, state_nx;
    logic [N_REQ-1:0] gnt_nx;
    logic [IW-1:0]    owner_nx;
    logic [IW-1:0]    rr_ptr, rr_ptr_nx;
    logic [CW-1:0]    beat_cnt, beat_cnt_nx, beat_inc;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    sel;
    logic             burst_end;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    assign accept     = gnt & req & {N_REQ{fifo_wenable}};
    assign fifo_winc  = |accept;
    assign sel        = IW'(onehot_to_idx(32'(gnt)));
    assign fifo_wdata = (gnt == '0) ? '0 : req_data[sel*DW +: DW];
    assign busy       = (state == BURST);
    assign beat_inc   = beat_cnt + 1'b1;

    always_comb begin
        state_nx    = state;
        gnt_nx      = gnt;
        owner_nx    = owner;
        rr_ptr_nx   = rr_ptr;
        beat_cnt_nx = beat_cnt;
        burst_end   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_nx           = '0;
                    gnt_nx[pick_idx] = 1'b1;
                    owner_nx         = pick_idx;
                    beat_cnt_nx      = '0;
                    state_nx         = BURST;
                end
            end
            BURST: begin
                // A stalled FIFO with the owner still requesting leaves everything frozen.
                if (!req[owner]) begin
                    burst_end = 1'b1;
                end else if (fifo_wenable) begin
                    beat_cnt_nx = beat_inc;
                    if (last[owner] || beat_inc == CW'(MAX_BURST)) burst_end = 1'b1;
                end
                if (burst_end) begin
                    gnt_nx    = '0;
                    rr_ptr_nx = owner;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            rr_ptr   <= IW'(N_REQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            owner    <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            beat_cnt <= beat_cnt_nx;
        end
    end

endmodule
